bcd_frame_accumulator: RTL and testbench

Converts the per-digit BCD stream from the calculator's display-decode stage into one binary result per display frame. The block sits directly downstream of the 7-segment-to-BCD decoder in the verification-side datapath. It accumulates digits most-significant first as value = value*10 + digit. It flags the "Er" display codes (0xA, 0xB) and any invalid code as an error, and presents a registered result with a one-cycle valid pulse for the scoreboard.

---
 rtl/bcd_frame_accumulator.sv | 99 +++++++++
 tb/tb_bcd_frame_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_frame_accumulator.sv
// Accumulates an MSD-first BCD digit stream into one binary value per display frame.
// Flags "Er"/illegal codes and digit overflow; emits a registered one-cycle result pulse.
module bcd_frame_accumulator #(
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned W          = 27
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         digit_vld,
   input  logic [3:0]   digit,
   input  logic         frame_start,
   input  logic         frame_end,
   output logic [W-1:0] value,
   output logic         err,
   output logic         ovf,
   output logic         result_vld,
   output logic         busy
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t         state, state_n;
   logic [W-1:0]   acc, acc_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           err_acc, err_n;
   logic           ovf_acc, ovf_n;
   logic           done;
   logic           bad_code;
   logic [W-1:0]   dnum;

   // Non-numeric codes contribute 0 to the sum; the error flag forces value to 0 anyway.
   assign bad_code = (digit >= 4'hA);
   assign dnum     = bad_code ? '0 : W'(digit);

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      err_n   = err_acc;
      ovf_n   = ovf_acc;
      done    = 1'b0;
      if (digit_vld) begin
         if (frame_start) begin
            acc_n   = dnum;
            cnt_n   = CW'(1);
            err_n   = bad_code;
            ovf_n   = 1'b0;
            state_n = ACCUM;
            if (frame_end) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end else if (state == ACCUM) begin
            if (cnt < CW'(MAX_DIGITS)) begin
               acc_n = (acc << 3) + (acc << 1) + dnum;
               cnt_n = cnt + CW'(1);
            end else begin
               ovf_n = 1'b1;
            end
            if (bad_code) err_n = 1'b1;
            if (frame_end) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         err_acc    <= 1'b0;
         ovf_acc    <= 1'b0;
         value      <= '0;
         err        <= 1'b0;
         ovf        <= 1'b0;
         result_vld <= 1'b0;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         cnt        <= cnt_n;
         err_acc    <= err_n;
         ovf_acc    <= ovf_n;
         result_vld <= done;
         if (done) begin
            value <= err_n ? '0 : acc_n;
            err   <= err_n;
            ovf   <= ovf_n;
         end
      end
   end

   assign busy = (state == ACCUM);

endmodule

// File: tb/tb_bcd_frame_accumulator.sv
// Scoreboard bench: a digit-list reference model predicts each frame result;
// a negedge monitor pops and compares whenever result_vld is seen.
module tb_bcd_frame_accumulator;

   localparam int unsigned MAXD = 8;
   localparam int unsigned W    = 27;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         digit_vld;
   logic [3:0]   digit;
   logic         frame_start;
   logic         frame_end;
   logic [W-1:0] value;
   logic         err;
   logic         ovf;
   logic         result_vld;
   logic         busy;

   bcd_frame_accumulator #(.MAX_DIGITS(MAXD), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_vld   (digit_vld),
      .digit       (digit),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .value       (value),
      .err         (err),
      .ovf         (ovf),
      .result_vld  (result_vld),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint v;
      bit     e;
      bit     o;
   } exp_t;

   exp_t   expq[$];
   exp_t   held;
   int     frame[$];
   bit     model_open;
   bit     mon_en;
   int     passed;
   int     total;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: value from the first MAXD digits, non-numeric codes count as 0.
   function automatic exp_t eval_frame();
      exp_t r;
      longint a;
      a   = 0;
      r.e = 1'b0;
      for (int i = 0; i < frame.size(); i++) begin
         if (frame[i] >= 10) r.e = 1'b1;
         if (i < MAXD) a = a * 10 + ((frame[i] < 10) ? frame[i] : 0);
      end
      r.o = (frame.size() > MAXD);
      r.v = r.e ? 0 : a;
      return r;
   endfunction

   task automatic beat(input bit v, input int d, input bit s, input bit e);
      digit_vld   = v;
      digit       = 4'(d);
      frame_start = s;
      frame_end   = e;
      @(posedge clk);
      if (v) begin
         if (s) begin
            frame.delete();
            frame.push_back(d);
            model_open = 1'b1;
         end else if (model_open) begin
            frame.push_back(d);
         end
         if (e && model_open) begin
            expq.push_back(eval_frame());
            model_open = 1'b0;
         end
      end
      #1;
      digit_vld   = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, int'($urandom_range(15)), 1'b0, 1'b0);
   endtask

   task automatic send(input int ds[$], input int gap);
      for (int i = 0; i < ds.size(); i++) begin
         beat(1'b1, ds[i], i == 0, i == ds.size() - 1);
         if (i != ds.size() - 1) idle(gap);
      end
   endtask

   task automatic do_reset();
      model_open = 1'b0;
      frame.delete();
      rst_n = 1'b0;
      #1;
      check("rst_value", longint'(value), 0);
      check("rst_err", longint'(err), 0);
      check("rst_ovf", longint'(ovf), 0);
      check("rst_result_vld", longint'(result_vld), 0);
      check("rst_busy", longint'(busy), 0);
      held = '{0, 1'b0, 1'b0};
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (result_vld) begin
            if (expq.size() == 0) begin
               total++;
               $display("FAIL unexpected_result_vld: got 1 expected 0 (t=%0t)", $time);
            end else begin
               exp_t x;
               x = expq.pop_front();
               check("value", longint'(value), x.v);
               check("err", longint'(err), longint'(x.e));
               check("ovf", longint'(ovf), longint'(x.o));
               held = x;
            end
         end else begin
            check("hold_value", longint'(value), held.v);
            check("hold_err", longint'(err), longint'(held.e));
            check("hold_ovf", longint'(ovf), longint'(held.o));
         end
         check("busy", longint'(busy), longint'(model_open));
      end
   end

   initial begin
      int ds[$];
      int len;
      bit abandon;
      passed      = 0;
      total       = 0;
      mon_en      = 1'b0;
      model_open  = 1'b0;
      held        = '{0, 1'b0, 1'b0};
      digit_vld   = 1'b0;
      digit       = 4'h0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      rst_n       = 1'b0;
      #1;
      do_reset();
      mon_en = 1'b1;
      idle(2);

      send('{1, 2, 3}, 0);
      idle(2);
      send('{9, 9, 9, 9, 9, 9, 9, 9}, 0);
      send('{9, 9, 9, 9, 9, 9, 9, 9, 9}, 0);
      send('{10, 11}, 0);
      send('{7}, 0);
      send('{0, 0, 4, 2}, 0);
      // partial frame 4,5 discarded by a restart
      beat(1'b1, 4, 1'b1, 1'b0);
      beat(1'b1, 5, 1'b0, 1'b0);
      beat(1'b1, 6, 1'b1, 1'b0);
      beat(1'b1, 1, 1'b0, 1'b1);
      idle(2);
      send('{3, 0, 8}, 3);
      beat(1'b1, 5, 1'b0, 1'b1);
      beat(1'b1, 2, 1'b0, 1'b0);
      idle(2);
      beat(1'b1, 5, 1'b1, 1'b0);
      beat(1'b1, 5, 1'b0, 1'b0);
      do_reset();
      send('{2}, 0);
      send('{12, 3, 15}, 1);
      idle(2);

      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(4) == 0)
            beat(1'b1, int'($urandom_range(15)), 1'b0, 1'($urandom_range(1)));
         len     = int'($urandom_range(1, 10));
         abandon = ($urandom_range(9) == 0);
         for (int i = 0; i < len; i++) begin
            int d;
            d = ($urandom_range(7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(9));
            beat(1'b1, d, i == 0, (i == len - 1) && !abandon);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
         end
         if (abandon && $urandom_range(1) == 0) do_reset();
         if ($urandom_range(2) == 0) idle(int'($urandom_range(1, 2)));
      end

      idle(4);
      check("queue_drained", longint'(expq.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
